// File: rtl/pc_redirect_controller.sv
// Front-end PC sequencer: applies EX-stage redirects, arbitrates them against
// load-use stalls and instruction-memory waits, and drives IF/ID, ID/EX control.
module pc_redirect_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EX_VALID,
  input  logic        BRANCH_SELECT,
  input  logic [31:0] TARGET_ADDRESS,
  input  logic        STALL,
  input  logic        IMEM_BUSY,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        PC_WRITE,
  output logic        IFID_WRITE,
  output logic        FLUSH_IFID,
  output logic        FLUSH_IDEX,
  output logic        REDIRECT_PENDING,
  output logic        HALTED,
  output logic [31:0] ERR_ADDR,
  output logic [31:0] REDIRECT_COUNT
);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HOLD = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pending;
  logic [31:0] r_err_addr;
  logic [31:0] r_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pending_nxt;
  logic [31:0] w_err_nxt;
  logic        w_take;
  logic        w_misaligned;
  logic        w_count_inc;
  logic        w_pc_write;
  logic        w_ifid_write;
  logic        w_flush_ifid;
  logic        w_flush_idex;

  assign w_take       = EX_VALID & BRANCH_SELECT;
  assign w_misaligned = (TARGET_ADDRESS[1:0] != 2'b00);
  assign w_pc_plus4   = r_pc + 32'd4;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = w_pc_plus4;
    w_pending_nxt = r_pending;
    w_err_nxt     = r_err_addr;
    w_count_inc   = 1'b0;
    w_pc_write    = 1'b0;
    w_ifid_write  = 1'b0;
    w_flush_ifid  = 1'b0;
    w_flush_idex  = 1'b0;

    case (r_state)
      S_RUN: begin
        // A take wins over STALL: the stalled ID instruction is on the wrong path.
        if (w_take && w_misaligned) begin
          w_err_nxt    = TARGET_ADDRESS;
          w_state_nxt  = S_HALT;
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
        end else if (w_take && IMEM_BUSY) begin
          w_pending_nxt = TARGET_ADDRESS;
          w_state_nxt   = S_HOLD;
          w_flush_ifid  = 1'b1;
          w_flush_idex  = 1'b1;
          w_count_inc   = 1'b1;
        end else if (w_take) begin
          w_pc_nxt     = TARGET_ADDRESS;
          w_pc_write   = 1'b1;
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          w_count_inc  = 1'b1;
        end else if (STALL) begin
          w_flush_idex = 1'b1;
        end else if (IMEM_BUSY) begin
          w_flush_ifid = 1'b1;
        end else begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
        end
      end

      S_HOLD: begin
        // EX and ID hold only bubbles here, so branch and stall inputs are ignored.
        w_flush_ifid = 1'b1;
        if (!IMEM_BUSY) begin
          w_pc_nxt    = r_pending;
          w_pc_write  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end

      S_HALT: begin
        w_flush_ifid = 1'b1;
        w_flush_idex = 1'b1;
      end

      default: begin
        w_state_nxt  = S_RUN;
        w_flush_ifid = 1'b1;
        w_flush_idex = 1'b1;
      end
    endcase

    if (w_flush_ifid) begin
      w_ifid_write = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_pending  <= 32'h0;
      r_err_addr <= 32'h0;
      r_count    <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_err_addr <= w_err_nxt;
      if (w_pc_write) begin
        r_pc <= w_pc_nxt;
      end
      if (w_count_inc) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  // While reset is held the pipeline is frozen and both pipeline registers bubble.
  assign PC_WRITE         = RESET_N & w_pc_write;
  assign IFID_WRITE       = RESET_N & w_ifid_write;
  assign FLUSH_IFID       = ~RESET_N | w_flush_ifid;
  assign FLUSH_IDEX       = ~RESET_N | w_flush_idex;
  assign PC               = r_pc;
  assign PC_PLUS4         = w_pc_plus4;
  assign REDIRECT_PENDING = (r_state == S_HOLD);
  assign HALTED           = (r_state == S_HALT);
  assign ERR_ADDR         = r_err_addr;
  assign REDIRECT_COUNT   = r_count;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Self-checking bench for pc_redirect_controller: behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pc_redirect_controller;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        EX_VALID = 1'b0;
  logic        BRANCH_SELECT = 1'b0;
  logic [31:0] TARGET_ADDRESS = 32'h0;
  logic        STALL = 1'b0;
  logic        IMEM_BUSY = 1'b0;
  logic [31:0] PC, PC_PLUS4, ERR_ADDR, REDIRECT_COUNT;
  logic        PC_WRITE, IFID_WRITE, FLUSH_IFID, FLUSH_IDEX, REDIRECT_PENDING, HALTED;

  int n_chk = 0;
  int n_err = 0;

  pc_redirect_controller #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EX_VALID(EX_VALID), .BRANCH_SELECT(BRANCH_SELECT),
    .TARGET_ADDRESS(TARGET_ADDRESS), .STALL(STALL), .IMEM_BUSY(IMEM_BUSY),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE),
    .FLUSH_IFID(FLUSH_IFID), .FLUSH_IDEX(FLUSH_IDEX), .REDIRECT_PENDING(REDIRECT_PENDING),
    .HALTED(HALTED), .ERR_ADDR(ERR_ADDR), .REDIRECT_COUNT(REDIRECT_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural front-end state as plain flags and numbers.
  logic [31:0] m_pc = 32'h0, m_pend = 32'h0, m_err = 32'h0, m_cnt = 32'h0;
  bit          m_halt = 0, m_hold = 0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_pc = 32'h0; m_pend = 32'h0; m_err = 32'h0; m_cnt = 32'h0;
      m_halt = 0; m_hold = 0;
    end else if (m_halt) begin
      // frozen until reset
    end else if (m_hold) begin
      if (!IMEM_BUSY) begin
        m_pc = m_pend;
        m_hold = 0;
      end
    end else if (EX_VALID && BRANCH_SELECT) begin
      if (TARGET_ADDRESS % 4 != 0) begin
        m_err = TARGET_ADDRESS;
        m_halt = 1;
      end else begin
        m_cnt = m_cnt + 1;
        if (IMEM_BUSY) begin
          m_pend = TARGET_ADDRESS;
          m_hold = 1;
        end else begin
          m_pc = TARGET_ADDRESS;
        end
      end
    end else if (!STALL && !IMEM_BUSY) begin
      m_pc = m_pc + 4;
    end
  end

  always @(negedge CLK) begin
    bit e_pcw, e_ifw, e_fi, e_fe;
    bit take;
    take = EX_VALID && BRANCH_SELECT;
    e_pcw = 0; e_ifw = 0; e_fi = 0; e_fe = 0;
    if (!RESET_N) begin
      e_fi = 1; e_fe = 1;
    end else if (m_halt) begin
      e_fi = 1; e_fe = 1; e_ifw = 1;
    end else if (m_hold) begin
      e_fi = 1; e_ifw = 1; e_pcw = !IMEM_BUSY;
    end else if (take) begin
      e_fi = 1; e_fe = 1; e_ifw = 1;
      e_pcw = (TARGET_ADDRESS % 4 == 0) && !IMEM_BUSY;
    end else if (STALL) begin
      e_fe = 1;
    end else if (IMEM_BUSY) begin
      e_fi = 1; e_ifw = 1;
    end else begin
      e_pcw = 1; e_ifw = 1;
    end
    chk("m_pc", PC, m_pc);
    chk("m_pc_plus4", PC_PLUS4, m_pc + 32'd4);
    chk("m_pc_write", {31'h0, PC_WRITE}, {31'h0, e_pcw});
    chk("m_ifid_write", {31'h0, IFID_WRITE}, {31'h0, e_ifw});
    chk("m_flush_ifid", {31'h0, FLUSH_IFID}, {31'h0, e_fi});
    chk("m_flush_idex", {31'h0, FLUSH_IDEX}, {31'h0, e_fe});
    chk("m_pending", {31'h0, REDIRECT_PENDING}, {31'h0, m_hold && RESET_N});
    chk("m_halted", {31'h0, HALTED}, {31'h0, m_halt && RESET_N});
    chk("m_err_addr", ERR_ADDR, m_err);
    chk("m_count", REDIRECT_COUNT, m_cnt);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic take(input logic [31:0] tgt);
    EX_VALID = 1'b1; BRANCH_SELECT = 1'b1; TARGET_ADDRESS = tgt;
  endtask

  task automatic untake();
    EX_VALID = 1'b0; BRANCH_SELECT = 1'b0;
  endtask

  initial begin
    #1 RESET_N = 1'b0;
    #2;
    chk("rst_pc", PC, 32'h0);
    chk("rst_pcw", {31'h0, PC_WRITE}, 32'h0);
    chk("rst_ifw", {31'h0, IFID_WRITE}, 32'h0);
    chk("rst_fi", {31'h0, FLUSH_IFID}, 32'h1);
    chk("rst_fe", {31'h0, FLUSH_IDEX}, 32'h1);
    chk("rst_cnt", REDIRECT_COUNT, 32'h0);
    #9 RESET_N = 1'b1;
    #1 chk("run_pcw", {31'h0, PC_WRITE}, 32'h1);
    chk("run_fi", {31'h0, FLUSH_IFID}, 32'h0);

    // sequential fetch
    step(4);
    chk("seq_pc", PC, 32'h10);

    // taken branch overrides stall
    take(32'h100); STALL = 1'b1;
    #1 chk("br_fi", {31'h0, FLUSH_IFID}, 32'h1);
    chk("br_fe", {31'h0, FLUSH_IDEX}, 32'h1);
    chk("br_pcw", {31'h0, PC_WRITE}, 32'h1);
    step(1); untake(); STALL = 1'b0;
    chk("br_pc", PC, 32'h100);
    chk("br_cnt", REDIRECT_COUNT, 32'h1);

    // redirect during memory wait
    take(32'h200); IMEM_BUSY = 1'b1;
    #1 chk("hold_enter_pcw", {31'h0, PC_WRITE}, 32'h0);
    step(1); untake();
    #1 chk("hold_pend1", {31'h0, REDIRECT_PENDING}, 32'h1);
    chk("hold_pc", PC, 32'h100);
    step(1);
    #1 chk("hold_pend2", {31'h0, REDIRECT_PENDING}, 32'h1);
    chk("hold_fi", {31'h0, FLUSH_IFID}, 32'h1);
    step(1); IMEM_BUSY = 1'b0;
    #1 chk("hold_pend3", {31'h0, REDIRECT_PENDING}, 32'h1);
    chk("hold_pcw", {31'h0, PC_WRITE}, 32'h1);
    step(1);
    chk("hold_pc_out", PC, 32'h200);
    chk("hold_pend_clr", {31'h0, REDIRECT_PENDING}, 32'h0);
    chk("hold_cnt", REDIRECT_COUNT, 32'h2);

    // load-use stall at 0x20
    take(32'h20);
    step(1); untake();
    chk("st_pc0", PC, 32'h20);
    STALL = 1'b1;
    #1 chk("st_ifw", {31'h0, IFID_WRITE}, 32'h0);
    chk("st_fe", {31'h0, FLUSH_IDEX}, 32'h1);
    step(1);
    chk("st_pc1", PC, 32'h20);
    step(1); STALL = 1'b0;
    chk("st_pc2", PC, 32'h20);
    step(1);
    chk("st_resume", PC, 32'h24);

    // bubble filter
    BRANCH_SELECT = 1'b1; TARGET_ADDRESS = 32'h300;
    step(1); BRANCH_SELECT = 1'b0;
    chk("bub_pc", PC, 32'h28);
    chk("bub_cnt", REDIRECT_COUNT, 32'h3);

    // wrap
    take(32'hFFFF_FFFC);
    step(1); untake();
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_plus4", PC_PLUS4, 32'h0);
    chk("wrap_cnt", REDIRECT_COUNT, 32'h4);
    step(1);
    chk("wrap_pc0", PC, 32'h0);
    step(1);
    chk("wrap_pc4", PC, 32'h4);

    // misaligned jump
    take(32'h102);
    #1 chk("mis_pcw", {31'h0, PC_WRITE}, 32'h0);
    chk("mis_fe", {31'h0, FLUSH_IDEX}, 32'h1);
    step(1); TARGET_ADDRESS = 32'h400;
    #1 chk("mis_halted", {31'h0, HALTED}, 32'h1);
    chk("mis_err", ERR_ADDR, 32'h102);
    chk("mis_pc", PC, 32'h4);
    step(2);
    chk("mis_pc_frozen", PC, 32'h4);
    chk("mis_cnt", REDIRECT_COUNT, 32'h4);
    untake();
    RESET_N = 1'b0;
    #1 chk("mis_rst_pc", PC, 32'h0);
    chk("mis_rst_halt", {31'h0, HALTED}, 32'h0);
    chk("mis_rst_err", ERR_ADDR, 32'h0);
    chk("mis_rst_cnt", REDIRECT_COUNT, 32'h0);
    #3 RESET_N = 1'b1;
    step(1);
    chk("post_rst_pc", PC, 32'h4);

    // reset discards a pending redirect
    take(32'h80); IMEM_BUSY = 1'b1;
    step(1); untake();
    chk("hr_pend", {31'h0, REDIRECT_PENDING}, 32'h1);
    RESET_N = 1'b0; IMEM_BUSY = 1'b0;
    #1 chk("hr_pend_clr", {31'h0, REDIRECT_PENDING}, 32'h0);
    chk("hr_pc", PC, 32'h0);
    #3 RESET_N = 1'b1;
    step(1);
    chk("hr_resume", PC, 32'h4);

    step(1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pc_redirect_controller.md
# pc_redirect_controller

Front-end sequencer for the RV32IM pipeline. Owns the program counter and applies PC redirects from the EX-stage branch control unit (taken branches and jumps). Arbitrates redirects against load-use stalls and instruction-memory wait states. Generates the IF/ID and ID/EX write-enable and flush controls, latches redirects that cannot be applied yet, halts on a misaligned target, and counts taken redirects.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  pipeline clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- EX_VALID  input  1  EX stage holds a real instruction (not a bubble).
- BRANCH_SELECT  input  1  redirect request from the branch control unit (combinational, EX stage).
- TARGET_ADDRESS  input  32  redirect target from the branch control unit.
- STALL  input  1  load-use hazard: hold PC and IF/ID, bubble into ID/EX.
- IMEM_BUSY  input  1  instruction memory has not returned the fetch for the current PC.
- PC  output  32  current fetch address (registered).
- PC_PLUS4  output  32  PC + 4, wraps modulo 2^32.
- PC_WRITE  output  1  PC updates at the next edge.
- IFID_WRITE  output  1  IF/ID register loads at the next edge.
- FLUSH_IFID  output  1  IF/ID loads a bubble at the next edge.
- FLUSH_IDEX  output  1  ID/EX loads a bubble at the next edge.
- REDIRECT_PENDING  output  1  a redirect is latched and waiting for IMEM_BUSY to drop.
- HALTED  output  1  misaligned-target halt (sticky until reset).
- ERR_ADDR  output  32  offending target captured on halt.
- REDIRECT_COUNT  output  32  number of redirects accepted since reset; wraps.

## Operation
- Redirect condition: take = EX_VALID & BRANCH_SELECT.
- Misaligned target: TARGET_ADDRESS[1:0] != 2'b00. There is no C extension, so a target is legal only when 4-byte aligned.
- FSM has three states: RUN, HOLD, HALT. Reset state is RUN.

RUN, evaluated in priority order:
- Take with a misaligned target:
  - ERR_ADDR <= TARGET_ADDRESS, go to HALT.
  - FLUSH_IFID = FLUSH_IDEX = 1; PC_WRITE = 0.
  - The counter does not increment.
- Take with IMEM_BUSY = 1:
  - Pending register <= TARGET_ADDRESS, go to HOLD.
  - FLUSH_IFID = FLUSH_IDEX = 1; PC_WRITE = 0.
  - Counter increments.
- Take with IMEM_BUSY = 0:
  - PC <= TARGET_ADDRESS; PC_WRITE = 1.
  - FLUSH_IFID = FLUSH_IDEX = 1; counter increments.
- Take always overrides STALL, because the stalled ID instruction lies on the wrong path.
- STALL (with or without IMEM_BUSY): PC_WRITE = 0, IFID_WRITE = 0, FLUSH_IDEX = 1, FLUSH_IFID = 0.
- IMEM_BUSY only: PC_WRITE = 0, FLUSH_IFID = 1, FLUSH_IDEX = 0.
- Otherwise: PC <= PC_PLUS4; PC_WRITE = 1, IFID_WRITE = 1, no flush.
- IFID_WRITE = 1 whenever FLUSH_IFID = 1, so the bubble is loaded.

HOLD:
- REDIRECT_PENDING = 1; FLUSH_IFID = 1; IFID_WRITE = 1; FLUSH_IDEX = 0.
- BRANCH_SELECT and STALL are ignored, since EX and ID hold only bubbles.
- When IMEM_BUSY = 0: PC <= pending, PC_WRITE = 1, go to RUN.
- While IMEM_BUSY stays 1: remain in HOLD.

HALT:
- HALTED = 1; PC_WRITE = 0; FLUSH_IFID = FLUSH_IDEX = 1.
- All inputs ignored; exit only through reset.

## Timing
- Reset (RESET_N low, asynchronous, no clock needed):
  - PC = RESET_PC, state = RUN, pending = 0, ERR_ADDR = 0, REDIRECT_COUNT = 0.
  - PC_WRITE = 0, IFID_WRITE = 0, FLUSH_IFID = 1, FLUSH_IDEX = 1, REDIRECT_PENDING = 0, HALTED = 0.
- Release of RESET_N is synchronous to the next rising edge; normal operation starts at the first edge after release.
- Control outputs are combinational from state and inputs. PC, ERR_ADDR, REDIRECT_COUNT and HALTED/REDIRECT_PENDING (decoded from state) are registered.
- Redirect latency: take sampled at edge n → PC = target after edge n; target instruction enters IF/ID at edge n+1. Penalty is 2 bubbles with IMEM_BUSY = 0, plus one per busy cycle in HOLD.
- Take and IMEM_BUSY falling in the same cycle: direct redirect, HOLD is not entered.
- PC + 4 from 32'hFFFF_FFFC wraps to 0. REDIRECT_COUNT wraps from 32'hFFFF_FFFF to 0.
- Reset asserted in HOLD or HALT discards the pending target and the halt immediately.

## Test plan
- Sequential fetch: reset with RESET_PC = 0, no stalls, 4 cycles → PC = 0, 4, 8, C, 10; PC_WRITE = 1, no flushes.
- Taken branch: EX_VALID = 1, BRANCH_SELECT = 1, TARGET = 32'h0000_0100 while STALL = 1 → one cycle with FLUSH_IFID = FLUSH_IDEX = 1; next PC = 0x100; REDIRECT_COUNT = 1.
- Redirect during memory wait: take with TARGET = 0x200 and IMEM_BUSY = 1 for 3 cycles → REDIRECT_PENDING = 1 for 3 cycles with FLUSH_IFID = 1 throughout; PC = 0x200 one edge after IMEM_BUSY falls; count = 1.
- Load-use stall: STALL = 1 for 2 cycles at PC = 0x20 → PC holds 0x20, IFID_WRITE = 0, FLUSH_IDEX = 1 each cycle; fetch resumes at 0x24.
- Misaligned jump: take with TARGET = 0x102 → HALTED = 1, ERR_ADDR = 0x102, PC frozen, count unchanged; further takes ignored; RESET_N pulse mid-halt → PC = RESET_PC, HALTED = 0.
- Bubble filter and wrap: BRANCH_SELECT = 1 with EX_VALID = 0 → no redirect; PC at 0xFFFF_FFFC advances to 0.
